pipelined_cla_addsub: RTL and testbench
=======================================

# pipelined_cla_addsub

Parameterised, pipelined N-bit carry-look-ahead adder with a valid/ready stream interface. It is the throughput-oriented successor to our single-cycle ripple-of-G/P adder. The operand is split into SEG-bit segments, and each segment is resolved by a combinational CLA in its own pipeline stage, with the inter-segment carry registered. It sits between operand-producing datapath logic and any consumer that can apply backpressure, and sustains one addition per clock.

## Interface
- N, 16, operand/sum width; must be a multiple of SEG
- SEG, 4, segment width per pipeline stage; stage count NS = N/SEG, NS >= 1
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept a beat this cycle
- a  input  N  operand A
- b  input  N  operand B
- cin  input  1  carry-in (borrow-in when sub=1)
- sub  input  1  subtract select; exists only with CLA_SUB_EN
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts the result this cycle
- s  output  N  sum/difference
- cout  output  1  carry-out of bit N-1
- ovf  output  1  two's-complement signed overflow

## Operation
- Effective operand: b_eff = b and c0 = cin. With CLA_SUB_EN and sub=1: b_eff = ~b and c0 = ~cin, so the result is a - b - cin, and cout=1 means no borrow.
- Stage k (0..NS-1) adds bits [k*SEG +: SEG] of a and b_eff, using the carry registered by stage k-1 (c0 for k=0). It produces SEG sum bits and a segment carry-out.
- Skew: operand bits for segments above k travel through stage-k registers until they are consumed.
- Deskew: sum bits already produced travel forward, so s emerges aligned at the last stage.
- Each stage holds a valid bit, so bubbles propagate normally.
- advance = !out_valid | out_ready. All stage registers, valid bits included, load only when advance=1.
- in_ready = advance (combinational). A beat is accepted on a rising edge where in_valid & in_ready.
- cout is the carry-out of stage NS-1.
- ovf = (a[N-1] == b_eff[N-1]) & (s[N-1] != a[N-1]). It is computed in stage NS-1 from the skewed MSBs.
- Data registers of invalid stages are don't-care for function. They are still reset to 0.

## Timing
- Reset, asynchronous with immediate effect: all valid bits 0, all data registers 0. Output values: out_valid=0, s=0, cout=0, ovf=0.
- in_ready = 1 while rst is deasserted and the pipe is not stalled.
- Latency: a beat accepted at edge t is presented with out_valid=1 after edge t+NS-1. For NS=1, the result is registered in the same edge it is accepted.
- Throughput: one beat per clock while out_ready=1.
- Stall: out_valid=1 & out_ready=0 freezes every stage and forces in_ready=0. s, cout and ovf hold stable until the beat is accepted.
- Simultaneous output handshake and new input: both complete on the same edge with no bubble.
- Reset mid-operation: all in-flight beats are discarded. No output handshake is ever presented for them.
- Carry wrap-around: a+b >= 2^N truncates s to N bits and sets cout=1. There is no other wrap state.

## Configuration
- CLA_SUB_EN defined: the sub port exists and the add/subtract behaviour above applies. sub is sampled with the beat and travels with it.
- CLA_SUB_EN undefined: no sub port; the block is add-only (b_eff=b, c0=cin).

## Structure
- Shared package cla_pkg holds:
  - the NS-derivation localparam helper
  - the elaboration-time check that N % SEG == 0
  - a typedef for the per-stage record: valid, carry, skewed a/b_eff, partial sum
- Sub-module cla_segment: combinational SEG-bit CLA.
  - Inputs: a, b, ci. Outputs: s, co, group P and G.
  - Instantiated once per stage with a generate loop.

## Test plan
All cases use N=16, SEG=4 (latency 4) unless stated.
- Reset then idle: rst pulse -> out_valid=0, s=0, cout=0, in_ready=1 after release.
- Full carry chain: a=16'hFFFF, b=16'h0001, cin=0 -> s=16'h0000, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance.
- Back-to-back stream of 8 random beats with out_ready=1: one result per clock, in order, each matching a+b+cin.
- Stall: hold out_ready=0 for 3 cycles with the pipe full -> in_ready=0, outputs frozen. Then release: no beat is lost or duplicated.
- Signed overflow: a=16'h7FFF, b=16'h0001 -> s=16'h8000, ovf=1, cout=0. With CLA_SUB_EN, sub=1, a=16'h0003, b=16'h0005, cin=0 -> s=16'hFFFE, cout=0.
- Reset mid-stream with 3 beats in flight: out_valid=0 immediately, none of the 3 results ever appear. A new beat afterwards returns a correct result after 4 cycles.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and configuration helpers for the pipelined CLA adder/subtractor.
// Operand width is fixed here, because the stage record below is sized from it.
package cla_pkg;

    localparam int CLA_N   = 16;
    localparam int CLA_SEG = 4;

    function automatic int cla_ns(input int n, input int seg);
        return n / seg;
    endfunction

    // Elaboration-time legality check: whole segments only, at least one stage.
    function automatic bit cla_cfg_ok(input int n, input int seg);
        return (seg > 0) && (n >= seg) && ((n % seg) == 0);
    endfunction

    // One pipeline stage: the valid bit, the carry out of this stage's segment,
    // operands still to be consumed by later stages, and the sum bits produced so far.
    typedef struct packed {
        logic             vld;
        logic             carry;
        logic [CLA_N-1:0] a;
        logic [CLA_N-1:0] b;
        logic [CLA_N-1:0] sum;
    } stage_t;

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit carry-look-ahead block with group propagate/generate.
// Latency: 0 cycles (pure logic).
// Backpressure: none, the enclosing stage register decides when results load.
module cla_segment
    import cla_pkg::*;
#(
    parameter int SEG = CLA_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           p,
    output logic           g
);
    logic [SEG-1:0] gen;
    logic [SEG-1:0] prop;
    logic [SEG:0]   c;
    logic           c_acc;
    logic           c_term;
    logic           g_acc;
    logic           g_term;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is the flat sum-of-products of generates and propagates below it.
    always_comb begin
        c      = '0;
        c_acc  = 1'b0;
        c_term = 1'b0;
        c[0]   = ci;
        for (int i = 0; i < SEG; i++) begin
            c_acc = ci;
            for (int j = 0; j <= i; j++) c_acc = c_acc & prop[j];
            for (int j = 0; j <= i; j++) begin
                c_term = gen[j];
                for (int k = j + 1; k <= i; k++) c_term = c_term & prop[k];
                c_acc = c_acc | c_term;
            end
            c[i+1] = c_acc;
        end
    end

    always_comb begin
        g_acc  = 1'b0;
        g_term = 1'b0;
        for (int j = 0; j < SEG; j++) begin
            g_term = gen[j];
            for (int k = j + 1; k < SEG; k++) g_term = g_term & prop[k];
            g_acc = g_acc | g_term;
        end
    end

    assign s  = prop ^ c[SEG-1:0];
    assign co = c[SEG];
    assign p  = &prop;
    assign g  = g_acc;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined N-bit CLA add (subtract with CLA_SUB_EN), one SEG-bit segment per stage.
// Latency: beat accepted at edge t is presented after edge t+NS-1.
// Backpressure: out_valid & !out_ready freezes every stage and drops in_ready.
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int N   = CLA_N,
    parameter int SEG = CLA_SEG
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
`ifdef CLA_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);
    localparam int NS = cla_ns(N, SEG);

    if (!cla_cfg_ok(N, SEG) || (N != CLA_N) || (SEG != CLA_SEG)) begin : g_bad_cfg
        $error("pipelined_cla_addsub: N must equal cla_pkg::CLA_N and be a multiple of SEG");
    end

    stage_t         st     [NS];
    stage_t         st_in  [NS];
    logic [SEG-1:0] seg_s  [NS];
    logic [NS-1:0]  seg_co;
    logic [NS-1:0]  seg_p;
    logic [NS-1:0]  seg_g;
    logic [N-1:0]   b_eff;
    logic           c0;
    logic           advance;
    logic           ovf_q;

    always_comb begin
`ifdef CLA_SUB_EN
        b_eff = sub ? ~b : b;
        c0    = sub ? ~cin : cin;
`else
        b_eff = b;
        c0    = cin;
`endif
    end

    // Stage k works on what stage k-1 registered; stage 0 works straight off the ports.
    always_comb begin
        st_in[0] = '{vld: in_valid, carry: c0, a: a, b: b_eff, sum: '0};
        for (int k = 1; k < NS; k++) st_in[k] = st[k-1];
    end

    for (genvar k = 0; k < NS; k++) begin : g_seg
        cla_segment #(.SEG(SEG)) u_seg (
            .a  (st_in[k].a[k*SEG +: SEG]),
            .b  (st_in[k].b[k*SEG +: SEG]),
            .ci (st_in[k].carry),
            .s  (seg_s[k]),
            .co (seg_co[k]),
            .p  (seg_p[k]),
            .g  (seg_g[k])
        );

        always_comb assert (seg_co[k] == (seg_g[k] | (seg_p[k] & st_in[k].carry)));
    end

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NS; k++) st[k] <= '0;
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < NS; k++) begin
                st[k]                   <= st_in[k];
                st[k].carry             <= seg_co[k];
                st[k].sum[k*SEG +: SEG] <= seg_s[k];
            end
            // The skewed MSBs reach the last stage together with the top segment.
            ovf_q <= (st_in[NS-1].a[N-1] == st_in[NS-1].b[N-1]) &&
                     (seg_s[NS-1][SEG-1] != st_in[NS-1].a[N-1]);
        end
    end

    assign out_valid = st[NS-1].vld;
    assign s         = st[NS-1].sum;
    assign cout      = st[NS-1].carry;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (N=16, SEG=4); exercises sub when CLA_SUB_EN is defined.
module tb_pipelined_cla_addsub;
    localparam int N   = 16;
    localparam int SEG = 4;
    localparam int NS  = N / SEG;
`ifdef CLA_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    exp_t exp_q[$];
    int   out_cyc[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_cla_addsub #(.N(N), .SEG(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as written.
    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                   input logic ci, input logic sb);
        exp_t   e;
        longint r_u;
        longint r_s;
        if (HAS_SUB && sb) begin
            r_u    = longint'(x) - longint'(y) - longint'(ci);
            r_s    = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
            e.cout = (r_u >= 0);
        end else begin
            r_u    = longint'(x) + longint'(y) + longint'(ci);
            r_s    = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
            e.cout = (r_u >= (longint'(1) << N));
        end
        e.s   = r_u[N-1:0];
        e.ovf = (r_s >= (longint'(1) << (N - 1))) || (r_s < -(longint'(1) << (N - 1)));
        return e;
    endfunction

    task automatic send_raw(input logic [N-1:0] x, input logic [N-1:0] y,
                            input logic ci, input logic sb, input exp_t e);
        bit acc;
        acc = 1'b0;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk);
        end
        chk("accept", acc, 1);
        if (acc) exp_q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic ci, input logic sb);
        send_raw(x, y, ci, sb, model(x, y, ci, sb));
    endtask

    task automatic send_rand();
        send(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic drain();
        @(posedge clk);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain_empty", exp_q.size(), 0);
        #1;
    endtask

    task automatic check_latency();
        for (int i = 0; i < NS; i++) begin
            @(negedge clk);
            chk("latency_out_valid", out_valid, (i == NS - 1));
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every output handshake, checks stall stability and in_ready.
    initial begin : monitor
        exp_t e;
        exp_t held;
        bit   was_stall;
        was_stall = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                was_stall = 1'b0;
            end else begin
                if (was_stall) begin
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_hold", {s, cout, ovf}, held);
                end
                if (!out_valid || out_ready) chk("in_ready_open", in_ready, 1);
                else                         chk("in_ready_stalled", in_ready, 0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got s=%0h cout=%0b with no beat outstanding", s, cout);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {s, cout, ovf}, e);
                        out_cyc.push_back(cyc);
                    end
                end
                was_stall = out_valid && !out_ready;
                held      = {s, cout, ovf};
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        int base;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_s", s, 0);
        chk("reset_cout", cout, 0);
        chk("reset_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Full carry chain, with exact latency.
        send_raw(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h0000, cout: 1'b1, ovf: 1'b0});
        check_latency();

        // Signed overflow and subtract corner cases.
        send_raw(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h8000, cout: 1'b0, ovf: 1'b1});
        send_raw(16'h8000, 16'h8000, 1'b1, 1'b0, '{s: 16'h0001, cout: 1'b1, ovf: 1'b1});
        if (HAS_SUB) begin
            send_raw(16'h0003, 16'h0005, 1'b0, 1'b1, '{s: 16'hFFFE, cout: 1'b0, ovf: 1'b0});
            send_raw(16'h8000, 16'h0001, 1'b0, 1'b1, '{s: 16'h7FFF, cout: 1'b1, ovf: 1'b1});
            send_raw(16'h0005, 16'h0005, 1'b1, 1'b1, '{s: 16'hFFFF, cout: 1'b0, ovf: 1'b0});
        end
        drain();

        // Back-to-back stream: one result per clock, in order.
        base = out_cyc.size();
        for (int i = 0; i < 8; i++) send_rand();
        drain();
        chk("b2b_count", out_cyc.size() - base, 8);
        if (out_cyc.size() >= base + 8) chk("b2b_spacing", out_cyc[base+7] - out_cyc[base], 7);

        // Stall with the pipe full.
        out_ready = 1'b0;
        for (int i = 0; i < NS; i++) send_rand();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_stall_out_valid", out_valid, 1);
            chk("full_stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send_rand();
        send_rand();
        drain();

        // Random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send_rand();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    if (!done) out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three beats in flight: none may ever emerge.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand();
        @(posedge clk);
        #2;
        chk("pre_reset_out_valid", out_valid, 1);
        base = out_cyc.size();
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_s", s, 0);
        chk("midreset_cout", cout, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("flushed_no_output", out_cyc.size() - base, 0);
        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        check_latency();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
